// File: rtl/led_pattern_pkg.sv
// Shared definitions for the LED pattern generator: mode encodings,
// scan/breathe ramp direction and default parameter values.
package led_pattern_pkg;

   localparam int NUM_LEDS_DEFAULT   = 8;
   localparam int PRESCALE_W_DEFAULT = 18;
   localparam int PWM_W_DEFAULT      = 8;

   typedef enum logic [1:0] {
      MODE_COUNT   = 2'd0,
      MODE_SCAN    = 2'd1,
      MODE_BREATHE = 2'd2,
      MODE_FREEZE  = 2'd3
   } mode_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

endpackage

// File: rtl/led_pattern_gen_pwm.sv
// led_pwm: free-running PWM counter plus compare against a level.
// pwm_out is combinational from the counter register; the caller registers it.
// Only instantiated when LED_PATTERN_BREATHE_EN is defined.
module led_pwm #(
   parameter int PWM_W = 8
) (
   input  logic             clk,
   input  logic             NOTRESET,
   input  logic [PWM_W-1:0] level,
   output logic             pwm_out
);

   logic [PWM_W-1:0] cnt_q;
   logic [PWM_W-1:0] cnt_d;

   // Counter advances every clock regardless of pause or mode.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
   end

   // Counter register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!NOTRESET) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign pwm_out = (cnt_q < level);

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: prescaled LED pattern generator with COUNT, SCAN,
// BREATHE and FREEZE modes. Optional feature macro: LED_PATTERN_BREATHE_EN
// (when undefined, BREATHE is not built and mode 2 acts as FREEZE).
module led_pattern_gen
   import led_pattern_pkg::*;
#(
   parameter int NUM_LEDS   = NUM_LEDS_DEFAULT,
   parameter int PRESCALE_W = PRESCALE_W_DEFAULT,
   parameter int PWM_W      = PWM_W_DEFAULT
) (
   input  logic                clk,
   input  logic                NOTRESET,
   input  logic [1:0]          mode,
   input  logic                pause,
   output logic [NUM_LEDS-1:0] leds,
   output logic                tick
);

   localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
   localparam logic [POS_W-1:0] POS_MAX    = POS_W'(NUM_LEDS - 1);
   localparam logic [POS_W-1:0] POS_MAX_M1 = POS_W'((NUM_LEDS > 1) ? NUM_LEDS - 2 : 0);

   logic [PRESCALE_W-1:0] pre_q, pre_d;
   mode_e                 mode_q, mode_d;
   logic [NUM_LEDS-1:0]   cnt_q, cnt_d;
   logic [NUM_LEDS-1:0]   leds_q, leds_d;
   logic [POS_W-1:0]      pos_q, pos_d;
   dir_e                  dir_q, dir_d;
   logic                  tickInt;
   logic                  modeChange;

`ifdef LED_PATTERN_BREATHE_EN
   logic [PWM_W-1:0] level_q, level_d;
   dir_e             levelDir_q, levelDir_d;
   logic             pwmOut;

   led_pwm #(
      .PWM_W(PWM_W)
   ) u_led_pwm (
      .clk     (clk),
      .NOTRESET(NOTRESET),
      .level   (level_q),
      .pwm_out (pwmOut)
   );
`endif

   assign tickInt    = (pre_q == '1) && !pause;
   assign modeChange = (mode != mode_q);

   // Next-state for prescaler and pattern state; a mode change overrides any tick.
   always_comb begin
      pre_d  = pause ? pre_q : pre_q + 1'b1;
      mode_d = mode_e'(mode);
      cnt_d  = cnt_q;
      pos_d  = pos_q;
      dir_d  = dir_q;
      leds_d = leds_q;
`ifdef LED_PATTERN_BREATHE_EN
      level_d    = level_q;
      levelDir_d = levelDir_q;
`endif
      if (modeChange) begin
         cnt_d = '0;
         pos_d = '0;
         dir_d = DIR_UP;
`ifdef LED_PATTERN_BREATHE_EN
         level_d    = '0;
         levelDir_d = DIR_UP;
`endif
         case (mode_e'(mode))
            MODE_COUNT:   leds_d = '0;
            MODE_SCAN:    leds_d = NUM_LEDS'(1);
`ifdef LED_PATTERN_BREATHE_EN
            MODE_BREATHE: leds_d = '0;
`endif
            default:      leds_d = leds_q;
         endcase
      end else begin
         case (mode_q)
            MODE_COUNT: begin
               if (tickInt) begin
                  cnt_d  = cnt_q + 1'b1;
                  leds_d = cnt_d;
               end
            end
            MODE_SCAN: begin
               if (tickInt) begin
                  if (NUM_LEDS == 1) begin
                     pos_d = '0;
                  end else if (dir_q == DIR_UP) begin
                     if (pos_q == POS_MAX) begin
                        dir_d = DIR_DOWN;
                        pos_d = POS_MAX_M1;
                     end else begin
                        pos_d = pos_q + 1'b1;
                     end
                  end else begin
                     if (pos_q == '0) begin
                        dir_d = DIR_UP;
                        pos_d = POS_W'(1);
                     end else begin
                        pos_d = pos_q - 1'b1;
                     end
                  end
                  leds_d = NUM_LEDS'(1) << pos_d;
               end
            end
`ifdef LED_PATTERN_BREATHE_EN
            MODE_BREATHE: begin
               if (tickInt) begin
                  if (levelDir_q == DIR_UP) begin
                     if (level_q == '1) begin
                        levelDir_d = DIR_DOWN;
                        level_d    = level_q - 1'b1;
                     end else begin
                        level_d = level_q + 1'b1;
                     end
                  end else begin
                     if (level_q == '0) begin
                        levelDir_d = DIR_UP;
                        level_d    = level_q + 1'b1;
                     end else begin
                        level_d = level_q - 1'b1;
                     end
                  end
               end
               leds_d = {NUM_LEDS{pwmOut}};
            end
`endif
            default: begin
               leds_d = leds_q;
            end
         endcase
      end
   end

   // State registers; synchronous reset overrides mode change, pause and tick.
   always_ff @(posedge clk) begin
      if (!NOTRESET) begin
         pre_q  <= '0;
         mode_q <= MODE_COUNT;
         cnt_q  <= '0;
         pos_q  <= '0;
         dir_q  <= DIR_UP;
         leds_q <= '0;
`ifdef LED_PATTERN_BREATHE_EN
         level_q    <= '0;
         levelDir_q <= DIR_UP;
`endif
      end else begin
         pre_q  <= pre_d;
         mode_q <= mode_d;
         cnt_q  <= cnt_d;
         pos_q  <= pos_d;
         dir_q  <= dir_d;
         leds_q <= leds_d;
`ifdef LED_PATTERN_BREATHE_EN
         level_q    <= level_d;
         levelDir_q <= levelDir_d;
`endif
      end
   end

   assign leds = leds_q;
   assign tick = tickInt;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen with NUM_LEDS=4, PRESCALE_W=2, PWM_W=2.
// Expected values are queued before each edge and popped after it.
`timescale 1ns/1ps
module tb_led_pattern_gen;

   localparam int NL = 4;
   localparam int PW = 2;
   localparam int WW = 2;

   typedef struct packed {
      logic [NL-1:0] leds;
      logic          tick;
   } exp_t;

   logic          clk      = 1'b0;
   logic          NOTRESET = 1'b0;
   logic [1:0]    mode     = 2'd0;
   logic          pause    = 1'b0;
   logic [NL-1:0] leds;
   logic          tick;

   exp_t expQ[$];
   int   cntQ[$];
   int   checks = 0;
   int   errors = 0;

   logic [NL-1:0] scanSeq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                  4'b0100, 4'b0010, 4'b0001, 4'b0010};

   led_pattern_gen #(
      .NUM_LEDS  (NL),
      .PRESCALE_W(PW),
      .PWM_W     (WW)
   ) dut (
      .clk     (clk),
      .NOTRESET(NOTRESET),
      .mode    (mode),
      .pause   (pause),
      .leds    (leds),
      .tick    (tick)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Hard time limit so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      NOTRESET = 1'b0;
      pause    = 1'b0;
      mode     = 2'd0;
      step();
      NOTRESET = 1'b1;
   endtask

   task automatic test_reset();
      exp_t e, g;
      NOTRESET = 1'b0;
      pause    = 1'b0;
      mode     = 2'd1;
      e.leds = '0; e.tick = 1'b0;
      expQ.push_back(e);
      step();
      g = expQ.pop_front();
      checks++;
      if ({leds, tick} !== g) begin
         errors++;
         $display("[TB] FAIL reset: leds=%b tick=%b expected leds=%b tick=%b", leds, tick, g.leds, g.tick);
      end
      NOTRESET = 1'b1;
      mode     = 2'd0;
   endtask

   task automatic test_count();
      exp_t e, g;
      doReset();
      for (int n = 1; n <= 68; n++) begin
         e.leds = NL'(n / 4);
         e.tick = (n % 4 == 3);
         expQ.push_back(e);
         step();
         g = expQ.pop_front();
         checks++;
         if ({leds, tick} !== g) begin
            errors++;
            $display("[TB] FAIL count n=%0d: leds=%b tick=%b expected leds=%b tick=%b", n, leds, tick, g.leds, g.tick);
         end
      end
   endtask

   task automatic test_scan();
      exp_t e, g;
      doReset();
      mode = 2'd1;
      for (int n = 1; n <= 31; n++) begin
         e.leds = scanSeq[n / 4];
         e.tick = (n % 4 == 3);
         expQ.push_back(e);
         step();
         g = expQ.pop_front();
         checks++;
         if ({leds, tick} !== g) begin
            errors++;
            $display("[TB] FAIL scan n=%0d: leds=%b tick=%b expected leds=%b tick=%b", n, leds, tick, g.leds, g.tick);
         end
      end
   endtask

   task automatic test_breathe();
      exp_t e, g;
`ifdef LED_PATTERN_BREATHE_EN
      int lvl [8] = '{0, 1, 2, 3, 2, 1, 0, 1};
      int ones;
      int want;
      doReset();
      mode = 2'd2;
      for (int w = 0; w < 8; w++) begin
         cntQ.push_back(lvl[w]);
         ones = 0;
         for (int j = 0; j < 4; j++) begin
            step();
            checks++;
            if (leds !== '0 && leds !== '1) begin
               errors++;
               $display("[TB] FAIL breathe_uniform w=%0d: leds=%b expected all bits equal", w, leds);
            end
            if (leds[0] === 1'b1) ones++;
         end
         want = cntQ.pop_front();
         checks++;
         if (ones != want) begin
            errors++;
            $display("[TB] FAIL breathe_duty w=%0d: on=%0d/4 expected %0d/4", w, ones, want);
         end
      end
`else
      doReset();
      for (int n = 1; n <= 12; n++) step();
      mode = 2'd2;
      for (int j = 1; j <= 16; j++) begin
         e.leds = 4'b0011;
         e.tick = (j % 4 == 3);
         expQ.push_back(e);
         step();
         g = expQ.pop_front();
         checks++;
         if ({leds, tick} !== g) begin
            errors++;
            $display("[TB] FAIL breathe_as_freeze j=%0d: leds=%b tick=%b expected leds=%b tick=%b", j, leds, tick, g.leds, g.tick);
         end
      end
`endif
   endtask

   task automatic test_pause();
      exp_t e, g;
      doReset();
      for (int n = 1; n <= 23; n++) step();
      checks++;
      if ({leds, tick} !== {4'b0101, 1'b1}) begin
         errors++;
         $display("[TB] FAIL pause_setup: leds=%b tick=%b expected leds=0101 tick=1", leds, tick);
      end
      pause = 1'b1;
      #1;
      checks++;
      if (tick !== 1'b0) begin
         errors++;
         $display("[TB] FAIL pause_tick_block: tick=%b expected 0", tick);
      end
      for (int n = 0; n < 10; n++) begin
         e.leds = 4'b0101; e.tick = 1'b0;
         expQ.push_back(e);
         step();
         g = expQ.pop_front();
         checks++;
         if ({leds, tick} !== g) begin
            errors++;
            $display("[TB] FAIL pause_hold n=%0d: leds=%b tick=%b expected leds=%b tick=%b", n, leds, tick, g.leds, g.tick);
         end
      end
      pause = 1'b0;
      #1;
      checks++;
      if (tick !== 1'b1) begin
         errors++;
         $display("[TB] FAIL pause_release_tick: tick=%b expected 1", tick);
      end
      e.leds = 4'b0110; e.tick = 1'b0;
      expQ.push_back(e);
      step();
      g = expQ.pop_front();
      checks++;
      if ({leds, tick} !== g) begin
         errors++;
         $display("[TB] FAIL pause_resume: leds=%b tick=%b expected leds=%b tick=%b", leds, tick, g.leds, g.tick);
      end
   endtask

   task automatic test_mode_change();
      exp_t e, g;
      doReset();
      for (int n = 1; n <= 31; n++) step();
      checks++;
      if ({leds, tick} !== {4'b0111, 1'b1}) begin
         errors++;
         $display("[TB] FAIL modechg_setup: leds=%b tick=%b expected leds=0111 tick=1", leds, tick);
      end
      mode = 2'd1;
      for (int n = 32; n <= 44; n++) begin
         if (n == 34) mode = 2'd3;
         if (n == 41) mode = 2'd0;
         if (n <= 40)      e.leds = 4'b0001;
         else if (n <= 43) e.leds = 4'b0000;
         else              e.leds = 4'b0001;
         e.tick = (n % 4 == 3);
         expQ.push_back(e);
         step();
         g = expQ.pop_front();
         checks++;
         if ({leds, tick} !== g) begin
            errors++;
            $display("[TB] FAIL modechg n=%0d: leds=%b tick=%b expected leds=%b tick=%b", n, leds, tick, g.leds, g.tick);
         end
      end
   endtask

   task automatic test_scan_reset();
      exp_t e, g;
      doReset();
      mode = 2'd1;
      for (int n = 1; n <= 12; n++) step();
      checks++;
      if (leds !== 4'b1000) begin
         errors++;
         $display("[TB] FAIL scanrst_setup: leds=%b expected 1000", leds);
      end
      #2 NOTRESET = 1'b0;
      #3 NOTRESET = 1'b1;
      for (int n = 13; n <= 18; n++) begin
         if (n == 14) NOTRESET = 1'b0;
         if (n == 15) NOTRESET = 1'b1;
         case (n)
            13:      e.leds = 4'b1000;
            14:      e.leds = 4'b0000;
            18:      e.leds = 4'b0010;
            default: e.leds = 4'b0001;
         endcase
         e.tick = (n == 17);
         expQ.push_back(e);
         step();
         g = expQ.pop_front();
         checks++;
         if ({leds, tick} !== g) begin
            errors++;
            $display("[TB] FAIL scanrst n=%0d: leds=%b tick=%b expected leds=%b tick=%b", n, leds, tick, g.leds, g.tick);
         end
      end
   endtask

   // Run every scenario in turn and report.
   initial begin
      $display("[TB] starting led_pattern_gen bench");
      test_reset();
      test_count();
      test_scan();
      test_breathe();
      test_pause();
      test_mode_change();
      test_scan_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
